// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a 2**ADD_WIDTH-entry FIFO register file.
// Turns push/pop requests into write enable and addresses, and keeps registered occupancy flags.
module fifo_ctrl #(
    parameter int ADD_WIDTH = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Wr,
    input  logic                 Rd,
    output logic                 W_en,
    output logic [ADD_WIDTH-1:0] W_addr,
    output logic [ADD_WIDTH-1:0] R_addr,
    output logic                 Full,
    output logic                 Empty,
    output logic                 Almost_full,
    output logic                 Almost_empty,
    output logic [ADD_WIDTH:0]   Count,
    output logic                 Overflow,
    output logic                 Underflow
);

    localparam int PW = ADD_WIDTH + 1;
    localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_ok, rd_ok;

    // A push into a full FIFO is allowed when a pop frees the head slot in the same cycle.
    assign rd_ok = Rd & ~empty_q;
    assign wr_ok = Wr & (~full_q | Rd);

    always_comb begin
        wptr_d  = wptr_q + PW'(wr_ok);
        rptr_d  = rptr_q + PW'(rd_ok);
        count_d = count_q + PW'(wr_ok) - PW'(rd_ok);
        // Flags come from next-state pointers so they line up with the pointers they describe.
        full_d  = (wptr_d[ADD_WIDTH-1:0] == rptr_d[ADD_WIDTH-1:0]) &&
                  (wptr_d[ADD_WIDTH] != rptr_d[ADD_WIDTH]);
        empty_d = (wptr_d == rptr_d);
        af_d    = (count_d >= AF_T);
        ae_d    = (count_d <= AE_T);
        ovf_d   = Wr & full_q & ~Rd;
        udf_d   = Rd & empty_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign W_en         = wr_ok;
    assign W_addr       = wptr_q[ADD_WIDTH-1:0];
    assign R_addr       = rptr_q[ADD_WIDTH-1:0];
    assign Full         = full_q;
    assign Empty        = empty_q;
    assign Almost_full  = af_q;
    assign Almost_empty = ae_q;
    assign Count        = count_q;
    assign Overflow     = ovf_q;
    assign Underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a queue-based FIFO model predicts each cycle,
// a monitor compares the controller (plus a bench-side register file) against it.
module tb_fifo_ctrl;

    localparam int AW = 3;
    localparam int D  = 8;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Wr = 1'b0;
    logic          Rd = 1'b0;
    logic          W_en;
    logic [AW-1:0] W_addr, R_addr;
    logic          Full, Empty, Almost_full, Almost_empty;
    logic [AW:0]   Count;
    logic          Overflow, Underflow;
    logic [7:0]    W_data = 8'h00;
    logic [7:0]    mem [D];

    fifo_ctrl #(.ADD_WIDTH(AW), .AF_THRESH(6), .AE_THRESH(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Wr(Wr), .Rd(Rd), .W_en(W_en),
        .W_addr(W_addr), .R_addr(R_addr), .Full(Full), .Empty(Empty),
        .Almost_full(Almost_full), .Almost_empty(Almost_empty), .Count(Count),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    // Register file the controller drives.
    always @(posedge Clk) if (W_en) mem[W_addr] <= W_data;

    typedef struct {
        int wen, waddr, raddr, pop, rdata;
        int cnt, full, empty, af, ae, ovf, udf;
    } exp_t;

    exp_t expq[$];
    int   model[$];
    int   wr_tot = 0, rd_tot = 0;
    int   checks = 0, failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit wr, input bit rd, input int d);
        exp_t e;
        bit   full, empty;
        @(negedge Clk);
        Wr = wr; Rd = rd; W_data = d[7:0];
        full  = (model.size() == D);
        empty = (model.size() == 0);
        e.wen   = int'(wr && (!full || rd));
        e.waddr = wr_tot % D;
        e.raddr = rd_tot % D;
        e.pop   = int'(rd && !empty);
        e.rdata = empty ? 0 : model[0];
        e.ovf   = int'(wr && full && !rd);
        e.udf   = int'(rd && empty);
        if (e.pop != 0) begin void'(model.pop_front()); rd_tot++; end
        if (e.wen != 0) begin model.push_back(d & 255); wr_tot++; end
        e.cnt   = model.size();
        e.full  = int'(model.size() == D);
        e.empty = int'(model.size() == 0);
        e.af    = int'(model.size() >= 6);
        e.ae    = int'(model.size() <= 1);
        expq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Wr = 0; Rd = 0;
        Reset_n = 0;
        #1;
        chk("rst_count", Count, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_full", Full, 0);
        chk("rst_ae", Almost_empty, 1);
        chk("rst_af", Almost_full, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_udf", Underflow, 0);
        chk("rst_waddr", W_addr, 0);
        chk("rst_raddr", R_addr, 0);
        model.delete();
        wr_tot = 0; rd_tot = 0;
        @(negedge Clk);
        Reset_n = 1;
    endtask

    // Monitor: comb outputs just before the edge, registered outputs just after.
    initial begin : monitor
        exp_t e;
        int wen, wa, ra, rdat;
        forever begin
            @(negedge Clk);
            #4;
            wen = W_en; wa = W_addr; ra = R_addr; rdat = mem[R_addr];
            @(posedge Clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("w_en", wen, e.wen);
                chk("w_addr", wa, e.waddr);
                chk("r_addr", ra, e.raddr);
                if (e.pop != 0) chk("r_data", rdat, e.rdata);
                chk("count", Count, e.cnt);
                chk("full", Full, e.full);
                chk("empty", Empty, e.empty);
                chk("almost_full", Almost_full, e.af);
                chk("almost_empty", Almost_empty, e.ae);
                chk("overflow", Overflow, e.ovf);
                chk("underflow", Underflow, e.udf);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int p;
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1, 0, i * 17);      // fill 0x11..0x88
        cycle(1, 0, 8'h99);                                    // overflow
        for (int i = 0; i < 8; i++) cycle(0, 1, 0);            // drain
        cycle(0, 1, 0);                                        // underflow
        cycle(1, 1, 8'h5a);                                    // Wr&Rd at empty
        for (int i = 0; i < 7; i++) cycle(1, 0, $urandom_range(0, 255));
        cycle(1, 1, 8'ha5);                                    // Wr&Rd at full
        for (int i = 0; i < 5; i++) cycle(0, 1, 0);            // down to 3
        for (int i = 0; i < 20; i++) cycle(1, 1, $urandom_range(0, 255));
        for (int i = 0; i < 2; i++) cycle(1, 0, $urandom_range(0, 255));
        cycle(0, 0, 0);
        do_reset();                                            // mid-stream at Count=5
        for (int ph = 0; ph < 3; ph++) begin
            p = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
            for (int i = 0; i < 150; i++)
                cycle($urandom_range(0, 99) < p, $urandom_range(0, 99) >= p,
                      $urandom_range(0, 255));
        end
        cycle(0, 0, 0);
        @(negedge Clk);
        @(negedge Clk);
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
